// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register.
//   EXC_ADEL        exception code for a misaligned instruction fetch
//   NOP             all-zero instruction inserted as a bubble
//   RS_*/RT_*       register-address field positions inside an instruction
//   if_id_payload_t payload carried from fetch to decode (default 32-bit widths)
package pipe_pkg;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } if_id_payload_t;

    // Instruction fetches must be word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pipe_payload_slot.sv
// One valid bit plus a payload register.
//   clk    rising-edge clock
//   reset  synchronous, active-high; empties the slot
//   clear  empties the slot (wins over load)
//   load   captures d and marks the slot valid
//   d      payload to capture
//   valid  slot holds a real entry
//   q      held payload; all zero whenever the slot is empty
module pipe_payload_slot #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Zeroing the payload on clear keeps an empty slot presenting a NOP
    // without any output muxing downstream.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, optional skid slot,
// NOP bubble insertion, flush, fetch alignment check and stall counter.
//   clk, reset            clock, synchronous active-high reset
//   flush                 kill everything held plus the instruction offered now
//   in_valid/in_ready     fetch-side handshake
//   in_pc/instr/exc/bd    fetch payload
//   out_ready/out_valid   decode-side handshake
//   out_pc/instr/exc/bd   decode payload (all zero when !out_valid)
//   out_rs/out_rt         register-address fields of the held instruction
//   reset_out             reset delayed one cycle for the next stage
//   stall_cnt             saturating count of out_valid & !out_ready cycles
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int EXC_W     = 5,
    parameter int RA_W      = 5,
    parameter int SKID      = 1,
    parameter int ALIGN_CHK = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [EXC_W-1:0] in_exc,
    input  logic             in_bd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic [EXC_W-1:0] out_exc,
    output logic             out_bd,
    output logic [RA_W-1:0]  out_rs,
    output logic [RA_W-1:0]  out_rt,
    output logic             reset_out,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PW = 2*XLEN + EXC_W + 1;

    logic          adel;
    logic [PW-1:0] in_pl;
    logic          accept, issue, main_free;
    logic          main_v, main_load, main_clr, main_from_skid;
    logic [PW-1:0] main_d, main_q;
    logic          skid_v, skid_load, skid_clr, skid_full_next;
    logic [PW-1:0] skid_q;

    // Misaligned fetch without an earlier exception becomes an ADEL with
    // a NOP body; an exception already raised by fetch is kept as is.
    assign adel  = (ALIGN_CHK != 0) && pc_misaligned(in_pc[1:0]) && (in_exc == '0);
    assign in_pl = {in_pc,
                    adel ? XLEN'(NOP) : in_instr,
                    adel ? EXC_W'(EXC_ADEL) : in_exc,
                    in_bd};

    assign accept    = in_valid & in_ready;
    assign issue     = main_v & out_ready;
    assign main_free = issue | ~main_v;

    // The skid always holds the older instruction, so it has first claim on
    // a free main slot; otherwise the input goes straight to main.
    assign main_from_skid = skid_v & main_free;
    assign main_load      = main_from_skid | (accept & main_free);
    assign main_d         = main_from_skid ? skid_q : in_pl;
    assign main_clr       = flush | (issue & ~main_load);

    // Input arrives while decode is stalled: park it in the skid.
    assign skid_load      = accept & ~main_free;
    assign skid_clr       = flush | main_from_skid;
    assign skid_full_next = ~flush & (skid_load | (skid_v & ~main_from_skid));

    pipe_payload_slot #(.W(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .clear (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            pipe_payload_slot #(.W(PW)) u_skid (
                .clk   (clk),
                .reset (reset),
                .clear (skid_clr),
                .load  (skid_load),
                .d     (in_pl),
                .valid (skid_v),
                .q     (skid_q)
            );

            // Ready is computed from next-cycle skid occupancy so fetch sees
            // a flop output; an empty skid always leaves room for one more.
            always_ff @(posedge clk) begin
                if (reset) in_ready_q <= 1'b0;
                else       in_ready_q <= ~skid_full_next;
            end
            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            assign skid_v   = 1'b0;
            assign skid_q   = '0;
            assign in_ready = ~reset & (out_ready | ~main_v);
        end
    endgenerate

    assign out_valid = main_v;
    assign out_pc    = main_q[PW-1 -: XLEN];
    assign out_instr = main_q[EXC_W+1 +: XLEN];
    assign out_exc   = main_q[1 +: EXC_W];
    assign out_bd    = main_q[0];
    assign out_rs    = RA_W'(out_instr[RS_HI:RS_LO]);
    assign out_rt    = RA_W'(out_instr[RT_HI:RT_LO]);

    always_ff @(posedge clk) begin
        reset_out <= reset;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (main_v && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a scoreboard queue holds the instructions the
// stage should currently be holding, oldest first; a monitor pops and
// compares every issued instruction.
module tb_if_id_skid_reg;
    import pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int EXC_W = 5;
    localparam int RA_W  = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk, reset, flush, in_valid, in_ready, in_bd;
    logic [XLEN-1:0]  in_pc, in_instr;
    logic [EXC_W-1:0] in_exc;
    logic             out_ready, out_valid, out_bd, reset_out;
    logic [XLEN-1:0]  out_pc, out_instr;
    logic [EXC_W-1:0] out_exc;
    logic [RA_W-1:0]  out_rs, out_rt;
    logic [CNT_W-1:0] stall_cnt;

    if_id_skid_reg #(
        .XLEN(XLEN), .EXC_W(EXC_W), .RA_W(RA_W),
        .SKID(1), .ALIGN_CHK(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_bd(in_bd),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .out_bd(out_bd),
        .out_rs(out_rs), .out_rt(out_rt),
        .reset_out(reset_out), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt_model = 0;
    bit mon_en = 1'b0;
    if_id_payload_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: state seen at a negedge is what the last posedge produced.
    always @(negedge clk) begin : monitor
        if_id_payload_t e;
        if (mon_en) begin
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("stall_cnt", stall_cnt, (cnt_model > CMAX) ? CMAX : cnt_model);
            if (!out_valid) begin
                chk("bubble_pc_instr", {out_pc, out_instr}, 64'h0);
                chk("bubble_misc", {out_exc, out_bd, out_rs, out_rt}, 64'h0);
            end else if (out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_pc", out_pc, e.pc);
                chk("issue_instr", out_instr, e.instr);
                chk("issue_exc_bd", {out_exc, out_bd}, {e.exc, e.bd});
                chk("issue_rs_rt", {out_rs, out_rt}, {e.instr[25:21], e.instr[20:16]});
            end
            if (out_valid && !out_ready) cnt_model++;
        end
    end

    // One cycle of stimulus; starts and ends at posedge+1. The expected
    // entry is queued at the edge where the handshake completes.
    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] exc, input bit bd, input bit ordy, input bit fl);
        logic rdy;
        if_id_payload_t e;
        in_valid = v; in_pc = pc; in_instr = instr; in_exc = exc; in_bd = bd;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else if (v && rdy) begin
            e.pc = pc;
            e.bd = bd;
            if (pc[1:0] != 2'b00 && exc == 5'd0) begin
                e.instr = 32'h0;
                e.exc   = 5'd4;
            end else begin
                e.instr = instr;
                e.exc   = exc;
            end
            exp_q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        logic [CNT_W-1:0] s0;
        logic [31:0] pc, ins;
        logic [4:0]  ex;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        in_exc = '0; in_bd = 1'b0; out_ready = 1'b0;

        // Reset
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_reset_out", reset_out, 1'b1);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_instr", out_instr, 32'h0);
            chk("rst_stall_cnt", stall_cnt, 0);
            chk("rst_in_ready", in_ready, 1'b0);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_reset_out", reset_out, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Back-to-back stream
        cyc(1'b1, 32'h3000, 32'h8C43_0004, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("stream_first_pc", out_pc, 32'h3000);
        cyc(1'b1, 32'h3004, 32'h00A6_2020, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("stream_second_pc", out_pc, 32'h3004);
        cyc(1'b1, 32'h3008, 32'h03E0_0008, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Decode stall fills main then skid
        s0 = stall_cnt;
        cyc(1'b1, 32'h3004, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3008, 32'h2345_6789, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("stall_hold_pc", out_pc, 32'h3004);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_delta", stall_cnt - s0, 3);
        repeat (3) idle(1'b1);

        // Flush with main and skid full and a new input offered
        cyc(1'b1, 32'h4000, 32'h1111_1111, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4004, 32'h2222_2222, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4008, 32'h3333_3333, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_instr", out_instr, 32'h0);
        chk("flush_in_ready", in_ready, 1'b1);
        idle(1'b1);
        chk("flush_dropped", out_valid, 1'b0);

        // Misaligned pc
        cyc(1'b1, 32'h3002, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("adel_exc", out_exc, 5'd4);
        chk("adel_instr", out_instr, 32'h0);
        cyc(1'b1, 32'h3006, 32'hDEAD_BEEF, 5'd6, 1'b0, 1'b1, 1'b0);
        chk("adel_keep_exc", out_exc, 5'd6);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pc  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            ins = $urandom;
            ex  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            cyc($urandom_range(0, 3) != 0, pc, ins, ex, 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (3) idle(1'b1);

        // Stall counter saturation
        cyc(1'b1, 32'h3010, 32'h0042_0000, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (CMAX + 1 + 5) idle(1'b0);
        chk("stall_saturated", stall_cnt, CMAX);
        repeat (3) idle(1'b1);

        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
